nebula_assembler_arbiter: RTL and testbench

Shares one nebula_packet_assembler among NUM_REQ local packet sources, e.g. DMA, CPU port and coherence engine.
Each packet is a single transaction. The arbiter picks a winner by QoS with round-robin tie-break and starvation escalation, then presents the winner's fields to the assembler. It holds them until accepted and blocks further grants until the assembler is no longer busy, so packets never interleave.
src_x/src_y are node constants tied at the top level and are not arbitrated.

---
 rtl/nebula_assembler_arbiter.sv | 151 +++++++++++++++
 tb/tb_nebula_assembler_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/nebula_assembler_arbiter.sv
// Shares one packet assembler among NUM_REQ sources: QoS pick, round-robin tie-break, starvation escalation.
// Latency: 1 cycle from req_valid/req_ready handshake to pkt_valid; fields held in registers until accepted.
// Backpressure: holds pkt_* while pkt_ready=0, and grants nothing until the assembler drops asm_busy.
module nebula_assembler_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int MAX_PAYLOAD_SIZE = 1024,
  parameter int STARVE_LIMIT     = 16,
  parameter int COORD_WIDTH      = 4,
  parameter int VC_ID_WIDTH      = 2,
  parameter int QOS_WIDTH        = 4,
  localparam int IDX_W           = $clog2(NUM_REQ),
  localparam int SIZE_W          = $clog2(MAX_PAYLOAD_SIZE),
  localparam int DATA_W          = MAX_PAYLOAD_SIZE * 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0][COORD_WIDTH-1:0]   req_dest_x,
  input  logic [NUM_REQ-1:0][COORD_WIDTH-1:0]   req_dest_y,
  input  logic [NUM_REQ-1:0][VC_ID_WIDTH-1:0]   req_vc_id,
  input  logic [NUM_REQ-1:0][QOS_WIDTH-1:0]     req_qos,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]        req_payload_data,
  input  logic [NUM_REQ-1:0][SIZE_W-1:0]        req_payload_size,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic                                  pkt_valid,
  output logic [COORD_WIDTH-1:0]                dest_x,
  output logic [COORD_WIDTH-1:0]                dest_y,
  output logic [VC_ID_WIDTH-1:0]                vc_id,
  output logic [QOS_WIDTH-1:0]                  qos,
  output logic [DATA_W-1:0]                     payload_data,
  output logic [SIZE_W-1:0]                     payload_size,
  input  logic                                  pkt_ready,
  input  logic                                  asm_busy,
  output logic [IDX_W-1:0]                      grant_id,
  output logic                                  grant_active,
  output logic                                  starve_event
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [QOS_WIDTH:0] STARVED_PRI = {1'b1, {QOS_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e                         state_q, state_d;
  logic [IDX_W-1:0]               rr_ptr_q;
  logic [IDX_W-1:0]               winner;
  logic [NUM_REQ-1:0][CNT_W-1:0]  wait_cnt_q, cnt_d;
  logic [NUM_REQ-1:0]             starved, hit;
  logic                           grant;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) starved[i] = (wait_cnt_q[i] == LIMIT);
  end

  // Circular scan from rr_ptr with strict '>' so the first index reached wins ties.
  always_comb begin : pick
    logic             found;
    logic [QOS_WIDTH:0] best, pri;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    found  = 1'b0;
    best   = '0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      idx = sum[IDX_W-1:0];
      pri = starved[idx] ? STARVED_PRI : {1'b0, req_qos[idx]};
      if (req_valid[idx] && (!found || pri > best)) begin
        found  = 1'b1;
        best   = pri;
        winner = idx;
      end
    end
  end

  // rst_n gate keeps req_ready low while reset is held with requests pending.
  assign grant        = rst_n && (state_q == IDLE) && (|req_valid) && !asm_busy;
  assign grant_active = (state_q != IDLE);

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ISSUE;
      ISSUE:   if (pkt_valid && pkt_ready) state_d = DRAIN;
      DRAIN:   if (!asm_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    cnt_d = wait_cnt_q;
    hit   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!req_valid[i] || (grant && winner == IDX_W'(i))) begin
        cnt_d[i] = '0;
      end else if (wait_cnt_q[i] != LIMIT) begin
        cnt_d[i] = wait_cnt_q[i] + 1'b1;
        hit[i]   = (wait_cnt_q[i] == LIMIT - 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q   <= '0;
      starve_event <= 1'b0;
    end else begin
      wait_cnt_q   <= cnt_d;
      starve_event <= |hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_valid    <= 1'b0;
      dest_x       <= '0;
      dest_y       <= '0;
      vc_id        <= '0;
      qos          <= '0;
      payload_data <= '0;
      payload_size <= '0;
      grant_id     <= '0;
      rr_ptr_q     <= '0;
    end else if (grant) begin
      pkt_valid    <= 1'b1;
      dest_x       <= req_dest_x[winner];
      dest_y       <= req_dest_y[winner];
      vc_id        <= req_vc_id[winner];
      qos          <= req_qos[winner];
      payload_data <= req_payload_data[winner];
      payload_size <= req_payload_size[winner];
      grant_id     <= winner;
      rr_ptr_q     <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end else if (pkt_valid && pkt_ready) begin
      pkt_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nebula_assembler_arbiter.sv
// Directed bench for nebula_assembler_arbiter: grant order, hold under backpressure, starvation, async reset.
module tb_nebula_assembler_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 128;
  localparam int SW  = 4;
  localparam int CWD = 4;
  localparam int VW  = 2;
  localparam int QW  = 4;

  logic                     clk, rst_n;
  logic [NR-1:0]            req_valid;
  logic [NR-1:0][CWD-1:0]   req_dest_x, req_dest_y;
  logic [NR-1:0][VW-1:0]    req_vc_id;
  logic [NR-1:0][QW-1:0]    req_qos;
  logic [NR-1:0][DW-1:0]    req_payload_data;
  logic [NR-1:0][SW-1:0]    req_payload_size;
  logic [NR-1:0]            req_ready;
  logic                     pkt_valid, pkt_ready, asm_busy;
  logic [CWD-1:0]           dest_x, dest_y;
  logic [VW-1:0]            vc_id;
  logic [QW-1:0]            qos;
  logic [DW-1:0]            payload_data;
  logic [SW-1:0]            payload_size;
  logic [1:0]               grant_id;
  logic                     grant_active, starve_event;

  int n_checks = 0;
  int n_fail   = 0;
  int accept_cnt = 0;
  int acc0, pulses;
  logic [146:0] t4_exp;
  logic [DW-1:0] t4_data;

  nebula_assembler_arbiter #(
    .NUM_REQ(NR), .MAX_PAYLOAD_SIZE(16), .STARVE_LIMIT(4),
    .COORD_WIDTH(CWD), .VC_ID_WIDTH(VW), .QOS_WIDTH(QW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_dest_x(req_dest_x), .req_dest_y(req_dest_y),
    .req_vc_id(req_vc_id), .req_qos(req_qos),
    .req_payload_data(req_payload_data), .req_payload_size(req_payload_size),
    .req_ready(req_ready), .pkt_valid(pkt_valid),
    .dest_x(dest_x), .dest_y(dest_y), .vc_id(vc_id), .qos(qos),
    .payload_data(payload_data), .payload_size(payload_size),
    .pkt_ready(pkt_ready), .asm_busy(asm_busy),
    .grant_id(grant_id), .grant_active(grant_active), .starve_event(starve_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (pkt_valid && pkt_ready) accept_cnt++;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [QW-1:0] q, input logic [CWD-1:0] dx,
                         input logic [CWD-1:0] dy, input logic [VW-1:0] vc,
                         input logic [SW-1:0] sz, input logic [DW-1:0] data);
    req_valid[i]        = 1'b1;
    req_qos[i]          = q;
    req_dest_x[i]       = dx;
    req_dest_y[i]       = dy;
    req_vc_id[i]        = vc;
    req_payload_size[i] = sz;
    req_payload_data[i] = data;
  endtask

  task automatic clear_reqs();
    req_valid        = '0;
    req_dest_x       = '0;
    req_dest_y       = '0;
    req_vc_id        = '0;
    req_qos          = '0;
    req_payload_data = '0;
    req_payload_size = '0;
  endtask

  // Waits (bounded) for a grant, checks it, then checks the packet appears one cycle later.
  task automatic await_grant(input string tag, input logic [NR-1:0] exp_mask,
                             input logic [1:0] exp_id, input bit drop);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, req_ready, exp_mask);
    @(posedge clk); #1;
    if (drop) req_valid[exp_id] = 1'b0;
    @(negedge clk);
    chk({tag, "_gid"}, grant_id, exp_id);
    chk({tag, "_pv"}, pkt_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; pkt_ready = 1'b1; asm_busy = 1'b0;
    clear_reqs();
    @(negedge clk);
    chk("rst_pv",   pkt_valid, 0);
    chk("rst_ga",   grant_active, 0);
    chk("rst_rdy",  req_ready, 0);
    chk("rst_gid",  grant_id, 0);
    chk("rst_se",   starve_event, 0);
    chk("rst_data", payload_data, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: lone requester 1
    @(posedge clk); #1;
    set_req(1, 4'd8, 4'd1, 4'd1, 2'd1, 4'd8, 64'hDEADBEEFCAFEBABE);
    await_grant("t1", 4'b0010, 2'd1, 1'b1);
    chk("t1_dx",   dest_x, 1);
    chk("t1_dy",   dest_y, 1);
    chk("t1_qos",  qos, 8);
    chk("t1_data", payload_data, 64'hDEADBEEFCAFEBABE);
    chk("t1_size", payload_size, 8);
    chk("t1_ga",   grant_active, 1);
    @(posedge clk); #1 asm_busy = 1'b1;
    @(negedge clk);
    chk("t1_pv_drain", pkt_valid, 0);
    @(posedge clk); #1 asm_busy = 1'b0;
    @(negedge clk);
    chk("t1_ga_drain", grant_active, 1);
    @(negedge clk);
    chk("t1_ga_idle", grant_active, 0);

    // 2: qos 12 beats qos 4, loser served next
    @(posedge clk); #1;
    set_req(0, 4'd4, 4'd0, 4'd1, 2'd0, 4'd2, 128'h55);
    set_req(2, 4'd12, 4'd3, 4'd2, 2'd3, 4'd6, 128'hAA);
    await_grant("t2a", 4'b0100, 2'd2, 1'b1);
    chk("t2a_dx", dest_x, 3);
    await_grant("t2b", 4'b0001, 2'd0, 1'b1);
    chk("t2b_data", payload_data, 128'h55);

    // 3: equal qos from reset, round robin 0,1,2,3,0
    @(posedge clk); #1 rst_n = 1'b0; clear_reqs();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 4'd8, 4'(i), 4'(i), 2'd0, 4'd4, 128'(i));
    await_grant("t3_0", 4'b0001, 2'd0, 1'b0);
    await_grant("t3_1", 4'b0010, 2'd1, 1'b0);
    await_grant("t3_2", 4'b0100, 2'd2, 1'b0);
    await_grant("t3_3", 4'b1000, 2'd3, 1'b0);
    await_grant("t3_4", 4'b0001, 2'd0, 1'b0);
    @(posedge clk); #1 clear_reqs();
    repeat (3) @(posedge clk);
    #1;

    // 4: backpressure hold, single accept, DRAIN while busy
    t4_data = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    t4_exp  = {1'b1, 4'd2, 4'd3, 2'd2, 4'd5, 4'd4, t4_data};
    pkt_ready = 1'b0;
    set_req(3, 4'd5, 4'd2, 4'd3, 2'd2, 4'd4, t4_data);
    await_grant("t4a", 4'b1000, 2'd3, 1'b1);
    acc0 = accept_cnt;
    set_req(0, 4'd1, 4'd7, 4'd7, 2'd1, 4'd1, 128'h77);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("t4_hold%0d", k),
          {pkt_valid, dest_x, dest_y, vc_id, qos, payload_size, payload_data}, t4_exp);
      chk($sformatf("t4_rdy%0d", k), req_ready, 0);
    end
    @(posedge clk); #1 pkt_ready = 1'b1;
    @(negedge clk);
    chk("t4_pv_last", pkt_valid, 1);
    @(posedge clk); #1 asm_busy = 1'b1;
    @(negedge clk);
    chk("t4_pv_drain", pkt_valid, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t4_drain_ga%0d", k), grant_active, 1);
      chk($sformatf("t4_drain_rdy%0d", k), req_ready, 0);
    end
    @(posedge clk); #1 asm_busy = 1'b0;
    @(negedge clk);
    chk("t4_rdy_lastdrain", req_ready, 0);
    chk("t4_accepts", accept_cnt - acc0, 1);
    await_grant("t4b", 4'b0001, 2'd0, 1'b1);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;

    // 5: starvation lets qos 0 beat qos 15
    set_req(0, 4'd0, 4'd1, 4'd0, 2'd0, 4'd1, 128'h10);
    set_req(1, 4'd15, 4'd0, 4'd1, 2'd0, 4'd1, 128'h11);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        asm_busy = (c == 2 || c == 3);
      end
      @(negedge clk);
      if (c < 5 && starve_event) pulses++;
      if (c == 0) chk("t5_first_r1", req_ready, 4'b0010);
      if (c == 4) chk("t5_starve_pulse", starve_event, 1);
      if (c == 5) chk("t5_starved_r0", req_ready, 4'b0001);
    end
    chk("t5_pulse_count", pulses, 1);
    @(posedge clk); #1 clear_reqs();
    repeat (4) @(posedge clk);
    #1;

    // 6: async reset mid-ISSUE, rr pointer restarts at 0
    pkt_ready = 1'b0;
    set_req(0, 4'd8, 4'd1, 4'd2, 2'd0, 4'd2, 128'h60);
    await_grant("t6a", 4'b0001, 2'd0, 1'b0);
    #2 rst_n = 1'b0;
    set_req(2, 4'd8, 4'd2, 4'd2, 2'd0, 4'd2, 128'h62);
    #1;
    chk("t6_rst_pv",  pkt_valid, 0);
    chk("t6_rst_ga",  grant_active, 0);
    chk("t6_rst_rdy", req_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1; pkt_ready = 1'b1;
    @(negedge clk);
    chk("t6_first_r0", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t6_gid", grant_id, 0);
    chk("t6_data", payload_data, 128'h60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
